// File: rtl/busarbiter_rr_pkg.sv
// Shared types and constants for the round-robin bus arbiter.
// Arbiter state encoding, core switch-safe state and default core count.
package busarbiter_rr_pkg;

  localparam int NCORES_DEF = 2;

  localparam logic [2:0] S_ID = 3'd2;

  typedef enum logic [1:0] {
    ARB_RUN    = 2'd0,
    ARB_DRAIN  = 2'd1,
    ARB_SWITCH = 2'd2,
    ARB_SETTLE = 2'd3
  } arb_state_e;

endpackage

// File: rtl/busarbiter_rr_next_sel.sv
// Round-robin successor picker: first active core after the current one.
// The current owner is never picked; found=0 when no other core is active.
module rr_next_sel #(
  parameter  int NCORES = 2,
  localparam int GW     = $clog2(NCORES)
) (
  input  logic [GW-1:0]     i_cur,
  input  logic [NCORES-1:0] i_active,
  output logic [GW-1:0]     o_next,
  output logic              o_found
);

  always_comb begin
    logic [GW-1:0] w_idx;
    o_next  = i_cur;
    o_found = 1'b0;
    w_idx   = '0;
    for (int i = 1; i < NCORES; i++) begin
      w_idx = i_cur + GW'(i);
      if (!o_found && i_active[w_idx]) begin
        o_next  = w_idx;
        o_found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/busarbiter_rr.sv
// Round-robin arbiter sharing one memory/peripheral bus among NCORES cores.
// Ownership changes only at a core switch-safe point via DRAIN/SWITCH/SETTLE.
import busarbiter_rr_pkg::*;

module busarbiter_rr #(
  parameter  int NCORES = NCORES_DEF,
  parameter  int REQ_W  = 104,
  parameter  int RSP_W  = 162,
  parameter  int QW     = 8,
  localparam int GW     = $clog2(NCORES)
) (
  input  logic                    CLK,
  input  logic                    RST_X,
  input  logic                    i_init_done,
  input  logic [QW-1:0]           i_quantum,
  input  logic [NCORES-1:0]       i_core_idle,
  input  logic [NCORES-1:0]       i_core_active,
  input  logic                    i_bus_busy,
  input  logic [NCORES*REQ_W-1:0] i_req_flat,
  output logic [REQ_W-1:0]        o_req,
  input  logic [RSP_W-1:0]        i_rsp,
  output logic [NCORES*RSP_W-1:0] o_rsp_flat,
  output logic [NCORES-1:0]       o_busy,
  output logic [GW-1:0]           o_grant,
  output logic [NCORES-1:0]       o_grant_oh,
  output logic                    o_switch
);

  arb_state_e    r_state;
  logic [GW-1:0] r_grant;
  logic [GW-1:0] r_next;
  logic [QW-1:0] r_cnt;
  logic [QW-1:0] r_qlat;
  logic          r_switch;

  logic [GW-1:0]     w_next;
  logic              w_found;
  logic              w_expired;
  logic              w_go;
  logic [REQ_W-1:0]  w_req_m [NCORES];

  rr_next_sel #(
    .NCORES (NCORES)
  ) u_next (
    .i_cur    (r_grant),
    .i_active (i_core_active),
    .o_next   (w_next),
    .o_found  (w_found)
  );

  // A parked owner forfeits the rest of its quantum.
  assign w_expired = (r_cnt >= r_qlat) || !i_core_active[r_grant];
  assign w_go      = w_expired && i_core_idle[r_grant]
                   && !i_bus_busy && w_found;

  always_ff @(posedge CLK or negedge RST_X) begin
    if (!RST_X) begin
      r_state  <= ARB_RUN;
      r_grant  <= '0;
      r_next   <= '0;
      r_cnt    <= '0;
      r_qlat   <= '0;
      r_switch <= 1'b0;
    end else if (i_init_done) begin
      unique case (r_state)
        ARB_RUN: begin
          if (w_go)
            r_state <= ARB_DRAIN;
          else if (r_cnt < r_qlat)
            r_cnt <= r_cnt + QW'(1);
        end
        ARB_DRAIN: begin
          r_next  <= w_next;
          r_state <= ARB_SWITCH;
        end
        ARB_SWITCH: begin
          r_grant  <= r_next;
          r_switch <= 1'b1;
          r_state  <= ARB_SETTLE;
        end
        ARB_SETTLE: begin
          r_switch <= 1'b0;
          r_cnt    <= '0;
          r_qlat   <= i_quantum;
          r_state  <= ARB_RUN;
        end
        default: r_state <= ARB_RUN;
      endcase
    end
  end

  assign o_grant  = r_grant;
  assign o_switch = r_switch;

  for (genvar k = 0; k < NCORES; k++) begin : g_core
    assign o_grant_oh[k] = (r_grant == GW'(k));
    assign o_busy[k] = (o_grant_oh[k] && r_state == ARB_RUN)
                     ? i_bus_busy : 1'b1;
    assign o_rsp_flat[k*RSP_W +: RSP_W] = o_grant_oh[k] ? i_rsp : '0;
    assign w_req_m[k] = o_grant_oh[k]
                      ? i_req_flat[k*REQ_W +: REQ_W] : '0;
  end

  always_comb begin
    o_req = '0;
    for (int k = 0; k < NCORES; k++)
      o_req = o_req | w_req_m[k];
  end

endmodule

// File: tb/tb_busarbiter_rr.sv
// Randomized bench for busarbiter_rr against a cycle-level ownership model.
// Four cores; directed phases followed by a long randomized phase.
module tb_busarbiter_rr;

  localparam int N  = 4;
  localparam int RW = 104;
  localparam int SW = 162;
  localparam int QW = 8;
  localparam int GW = 2;

  logic              CLK = 1'b0;
  logic              RST_X;
  logic              i_init_done;
  logic [QW-1:0]     i_quantum;
  logic [N-1:0]      i_core_idle;
  logic [N-1:0]      i_core_active;
  logic              i_bus_busy;
  logic [N*RW-1:0]   i_req_flat;
  logic [RW-1:0]     o_req;
  logic [SW-1:0]     i_rsp;
  logic [N*SW-1:0]   o_rsp_flat;
  logic [N-1:0]      o_busy;
  logic [GW-1:0]     o_grant;
  logic [N-1:0]      o_grant_oh;
  logic              o_switch;

  busarbiter_rr #(
    .NCORES (N),
    .REQ_W  (RW),
    .RSP_W  (SW),
    .QW     (QW)
  ) dut (
    .CLK           (CLK),
    .RST_X         (RST_X),
    .i_init_done   (i_init_done),
    .i_quantum     (i_quantum),
    .i_core_idle   (i_core_idle),
    .i_core_active (i_core_active),
    .i_bus_busy    (i_bus_busy),
    .i_req_flat    (i_req_flat),
    .o_req         (o_req),
    .i_rsp         (i_rsp),
    .o_rsp_flat    (o_rsp_flat),
    .o_busy        (o_busy),
    .o_grant       (o_grant),
    .o_grant_oh    (o_grant_oh),
    .o_switch      (o_switch)
  );

  always #5 CLK = ~CLK;

  int n_tests = 0;
  int n_fail  = 0;

  // Model: owner, cycles left in the handover gap (3=drain..1=settle),
  // RUN cycles counted so far, latched quantum, chosen successor.
  int m_owner, m_gap, m_run, m_q, m_next;
  int cyc;

  task automatic chk(input string tag,
                     input logic [N*SW-1:0] act,
                     input logic [N*SW-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask

  function automatic int succ(int cur, logic [N-1:0] act);
    for (int i = 1; i < N; i++)
      if (act[(cur + i) % N]) return (cur + i) % N;
    return cur;
  endfunction

  task automatic model_reset();
    m_owner = 0; m_gap = 0; m_run = 0; m_q = 0; m_next = 0;
  endtask

  task automatic model_step();
    bit others;
    if (!RST_X || !i_init_done) return;
    others = 1'b0;
    for (int k = 0; k < N; k++)
      if (k != m_owner && i_core_active[k]) others = 1'b1;
    case (m_gap)
      0: begin
        if ((m_run >= m_q || !i_core_active[m_owner]) &&
            i_core_idle[m_owner] && !i_bus_busy && others)
          m_gap = 3;
        else if (m_run < m_q)
          m_run++;
      end
      3: begin m_next = succ(m_owner, i_core_active); m_gap = 2; end
      2: begin m_owner = m_next; m_gap = 1; end
      default: begin m_gap = 0; m_run = 0; m_q = int'(i_quantum); end
    endcase
  endtask

  task automatic check_outputs();
    logic [N-1:0]   eb;
    logic [N*SW-1:0] er;
    for (int k = 0; k < N; k++) begin
      eb[k] = (k != m_owner) ? 1'b1 : (m_gap == 0 ? i_bus_busy : 1'b1);
      er[k*SW +: SW] = (k == m_owner) ? i_rsp : '0;
    end
    chk("grant",  o_grant, m_owner[GW-1:0]);
    chk("onehot", o_grant_oh, N'(1) << m_owner);
    chk("switch", o_switch, m_gap == 1);
    chk("busy",   o_busy, eb);
    chk("rsp",    o_rsp_flat, er);
    chk("req",    o_req, i_req_flat[m_owner*RW +: RW]);
  endtask

  task automatic gen_inputs(input int mode);
    for (int w = 0; w < N*RW/32; w++) i_req_flat[w*32 +: 32] = $urandom;
    i_rsp = SW'({$urandom, $urandom, $urandom,
                 $urandom, $urandom, $urandom});
    case (mode)
      0: begin
        i_init_done = 1; i_core_active = 4'b1111; i_core_idle = 4'b1111;
        i_bus_busy = 0; i_quantum = 3;
      end
      1: begin
        i_init_done = 1; i_core_active = 4'b1011; i_core_idle = 4'b1111;
        i_bus_busy = 0; i_quantum = 2;
      end
      2: begin
        i_init_done = 1; i_core_active = 4'b0001;
        i_core_idle = N'($urandom); i_bus_busy = 1'($urandom);
        i_quantum = QW'($urandom_range(0, 3));
      end
      3: begin
        i_init_done = ($urandom_range(0, 9) != 0);
        i_core_active = N'($urandom);
        i_core_idle = N'($urandom) | N'($urandom);
        i_bus_busy = ($urandom_range(0, 3) == 0);
        i_quantum = QW'($urandom_range(0, 5));
      end
      default: begin
        i_init_done = 0; i_core_active = N'($urandom);
        i_core_idle = N'($urandom); i_bus_busy = 1'($urandom);
        i_quantum = QW'($urandom);
      end
    endcase
  endtask

  // Entered right after a falling edge; returns on the next one.
  task automatic run_cycle(input int mode);
    gen_inputs(mode);
    #1;
    check_outputs();
    model_step();
    cyc++;
    @(negedge CLK);
  endtask

  int sw_cyc[$];
  int sw_gnt[$];
  int g2, late_sw, lim;

  initial begin
    cyc = 0;
    RST_X = 0;
    model_reset();
    @(negedge CLK);
    gen_inputs(0);
    i_bus_busy = 1;
    #1;
    check_outputs();
    i_bus_busy = 0;
    #1;
    check_outputs();
    RST_X = 1;

    // All active, quantum 3: fixed rotation and pulse spacing.
    cyc = 0;
    repeat (35) begin
      gen_inputs(0);
      #1;
      check_outputs();
      if (o_switch) begin
        sw_cyc.push_back(cyc);
        sw_gnt.push_back(int'(o_grant));
      end
      model_step();
      cyc++;
      @(negedge CLK);
    end
    chk("sw_count", sw_cyc.size(), 5);
    if (sw_cyc.size() == 5) begin
      chk("sw_first", sw_cyc[0], 3);
      for (int i = 0; i < 5; i++)
        chk("rot_grant", sw_gnt[i], (i + 1) % N);
      for (int i = 1; i < 5; i++)
        chk("sw_period", sw_cyc[i] - sw_cyc[i-1], 7);
    end

    // Core 2 parked: never handed the bus once the mask is in effect.
    g2 = 0;
    for (int i = 0; i < 40; i++) begin
      gen_inputs(1);
      #1;
      check_outputs();
      if (i >= 10 && o_switch && o_grant == 2'd2) g2++;
      model_step();
      @(negedge CLK);
    end
    chk("skip_parked", g2, 0);

    // Only core 0 active: ownership settles on 0 and stays.
    late_sw = 0;
    for (int i = 0; i < 40; i++) begin
      gen_inputs(2);
      #1;
      check_outputs();
      if (i >= 15 && o_switch) late_sw++;
      model_step();
      @(negedge CLK);
    end
    chk("solo_noswitch", late_sw, 0);
    chk("solo_grant", o_grant, 2'd0);

    repeat (3000) run_cycle(3);

    // Frozen while init is low.
    repeat (10) run_cycle(4);

    // Asynchronous reset while the grant register is being loaded.
    lim = 0;
    while (m_gap != 2 && lim < 100) begin
      run_cycle(0);
      lim++;
    end
    chk("reach_switch", lim < 100, 1'b1);
    @(posedge CLK);
    #2;
    RST_X = 0;
    model_reset();
    #1;
    chk("rst_grant",  o_grant, 2'd0);
    chk("rst_switch", o_switch, 1'b0);
    chk("rst_busy",   o_busy, {3'b111, i_bus_busy});
    @(negedge CLK);
    repeat (2) run_cycle(3);
    RST_X = 1;
    repeat (200) run_cycle(3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
